ultrasonic_ranger: RTL

Drives one HC-SR04-class ultrasonic sensor through a full measurement cycle: trigger pulse, echo capture, round-trip-to-centimetre conversion, timeout and thresholded presence detection with hysteresis. It sits between the periodic measurement-request pulse generator and the object-counting/LCD logic. Per measurement it delivers a one-cycle-valid distance word and a clean, level-stable `object_detected_o` for downstream edge counting.

---
 rtl/ultrasonic_ranger.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranger: trigger pulse, synchronised echo timing, cm conversion,
// timeout and thresholded presence detection with release hysteresis.
module ultrasonic_ranger #(
    parameter int unsigned CLOCK_FREQ        = 50_000_000,
    parameter int unsigned TRIG_US           = 10,
    parameter int unsigned TIMEOUT_US        = 30000,
    parameter int unsigned CYCLES_PER_CM     = 2900,
    parameter int unsigned DIST_THRESHOLD_CM = 10,
    parameter int unsigned HYST_CM           = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       echo_i,
    output logic       trigger_o,
    output logic       busy_o,
    output logic [8:0] dist_cm_o,
    output logic       valid_o,
    output logic       timeout_o,
    output logic       object_detected_o
);

    // Divide before multiplying so the product stays within 32 bits.
    localparam int unsigned TrigCycles    = CLOCK_FREQ / 1_000_000 * TRIG_US;
    localparam int unsigned TimeoutCycles = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TrigW         = $clog2(TrigCycles + 1);
    localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
    localparam int unsigned PrescW        = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam logic [8:0]  DistMax       = 9'd511;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync_q;
    logic [TrigW-1:0]  trig_cnt_q, trig_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [8:0]        cm_q, cm_d;
    logic [8:0]        dist_q, dist_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic              obj_q, obj_d;

    logic       echo_rise, echo_fall;
    logic       finish, finish_tmo;
    logic [8:0] finish_dist, result;

    // sync_q[1] is the synchronised echo, sync_q[2] its previous value.
    assign echo_rise = sync_q[1] & ~sync_q[2];
    assign echo_fall = ~sync_q[1] & sync_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            trig_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            presc_q    <= '0;
            cm_q       <= '0;
            dist_q     <= '0;
            tmo_flag_q <= 1'b0;
            obj_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], echo_i};
            trig_cnt_q <= trig_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            presc_q    <= presc_d;
            cm_q       <= cm_d;
            dist_q     <= dist_d;
            tmo_flag_q <= tmo_flag_d;
            obj_q      <= obj_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trig_cnt_d  = trig_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        presc_d     = presc_q;
        cm_d        = cm_q;
        dist_d      = dist_q;
        tmo_flag_d  = tmo_flag_q;
        obj_d       = obj_q;
        finish      = 1'b0;
        finish_tmo  = 1'b0;
        finish_dist = cm_q;
        result      = cm_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StTrig;
                    trig_cnt_d = '0;
                end
            end
            StTrig: begin
                if (trig_cnt_q == TrigW'(TrigCycles - 1)) begin
                    state_d   = StWaitRise;
                    tmo_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + TrigW'(1);
                end
            end
            StWaitRise: begin
                if (tmo_cnt_q == TmoW'(TimeoutCycles)) begin
                    finish     = 1'b1;
                    finish_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    if (echo_rise) begin
                        state_d = StMeasure;
                        presc_d = '0;
                        cm_d    = '0;
                    end
                end
            end
            StMeasure: begin
                if (tmo_cnt_q == TmoW'(TimeoutCycles)) begin
                    finish     = 1'b1;
                    finish_tmo = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    if (presc_q == PrescW'(CYCLES_PER_CM - 1)) begin
                        presc_d = '0;
                        if (cm_q != DistMax) begin
                            cm_d = cm_q + 9'd1;
                        end
                    end else begin
                        presc_d = presc_q + PrescW'(1);
                    end
                    // The fall cycle itself still counts toward the echo width.
                    if (echo_fall) begin
                        finish      = 1'b1;
                        finish_dist = cm_d;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            result     = finish_tmo ? DistMax : finish_dist;
            state_d    = StDone;
            tmo_flag_d = finish_tmo;
            dist_d     = result;
            if (finish_tmo) begin
                obj_d = 1'b0;
            end else if (32'(result) <= DIST_THRESHOLD_CM) begin
                obj_d = 1'b1;
            end else if (32'(result) > DIST_THRESHOLD_CM + HYST_CM) begin
                obj_d = 1'b0;
            end
        end
    end

    assign trigger_o         = (state_q == StTrig);
    assign busy_o            = (state_q != StIdle);
    assign valid_o           = (state_q == StDone);
    assign timeout_o         = (state_q == StDone) & tmo_flag_q;
    assign dist_cm_o         = dist_q;
    assign object_detected_o = obj_q;

endmodule
